// File: rtl/axi_master_read_channel_if.sv
// AXI read address/data channel bundle between a read master and a read slave.
interface axi_master_read_channel_if #(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned READ_CHANNEL_WIDTH = 32,
  parameter int unsigned READ_BURST_LEN     = 8
);

  logic                          ARREADY;
  logic [ADDR_WIDTH-1:0]         ARADDR;
  logic                          ARVALID;
  logic [READ_BURST_LEN-1:0]     ARLEN;
  logic [2:0]                    ARSIZE;
  logic [1:0]                    ARBURST;
  logic                          RVALID;
  logic [READ_CHANNEL_WIDTH-1:0] RDATA;
  logic                          RLAST;
  logic [1:0]                    RRESP;
  logic                          RREADY;

  modport master (
    input  ARREADY, RVALID, RDATA, RLAST, RRESP,
    output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, RREADY
  );

  modport slave (
    output ARREADY, RVALID, RDATA, RLAST, RRESP,
    input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, RREADY
  );

endinterface

// File: rtl/axi_master_read_channel.sv
// Single-outstanding AXI burst-read initiator: one AR per client request,
// R beats streamed straight through to the client, done/err on completion.
module axi_master_read_channel #(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned READ_CHANNEL_WIDTH = 32,
  parameter int unsigned READ_BURST_LEN     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [READ_BURST_LEN-1:0]     req_len,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [READ_CHANNEL_WIDTH-1:0] rsp_data,
  output logic                          rsp_last,
  output logic                          done,
  output logic                          err,
  axi_master_read_channel_if.master     axi
);

  // One extra bit so a 256-beat burst can count past ARLEN without wrapping.
  localparam int unsigned CNT_W     = READ_BURST_LEN + 1;
  localparam int unsigned SIZE_CODE = $clog2(READ_CHANNEL_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [ADDR_WIDTH-1:0]     ar_addr;
  logic [READ_BURST_LEN-1:0] ar_len;
  logic [CNT_W-1:0]          beat_cnt;
  logic                      err_acc;
  logic                      done_q;
  logic                      err_q;

  logic req_fire;
  logic r_fire;
  logic resp_bad;
  logic last_bad;
  logic beat_bad;

  // Handshake and per-beat error qualification.
  always_comb begin
    req_fire = 1'b0;
    r_fire   = 1'b0;
    resp_bad = 1'b0;
    last_bad = 1'b0;
    beat_bad = 1'b0;
    req_fire = (state == IDLE) && req_valid && !rst;
    r_fire   = (state == DATA) && axi.RVALID && rsp_ready && !rst;
    resp_bad = (axi.RRESP == 2'b10) || (axi.RRESP == 2'b11);
    last_bad = axi.RLAST != (beat_cnt == CNT_W'(ar_len));
    beat_bad = resp_bad || last_bad;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_fire) state_next = ADDR;
      ADDR:    if (axi.ARREADY) state_next = DATA;
      DATA:    if (r_fire && axi.RLAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, beat counting, error accumulation and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_addr  <= '0;
      ar_len   <= '0;
      beat_cnt <= '0;
      err_acc  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (req_fire) begin
        ar_addr  <= req_addr;
        ar_len   <= req_len;
        beat_cnt <= '0;
        err_acc  <= 1'b0;
      end
      if (r_fire) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (beat_bad) err_acc <= 1'b1;
      end
      done_q <= (state_next == DONE);
      err_q  <= (state_next == DONE) && (err_acc || beat_bad);
    end
  end

  // Output decode; R channel is a straight pass-through while in DATA.
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = axi.RDATA;
    rsp_last    = 1'b0;
    axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b0;
    axi.ARADDR  = ar_addr;
    axi.ARLEN   = ar_len;
    axi.ARSIZE  = 3'(SIZE_CODE);
    axi.ARBURST = 2'b01;
    done        = done_q;
    err         = err_q;
    case (state)
      IDLE: req_ready = !rst;
      ADDR: axi.ARVALID = 1'b1;
      DATA: begin
        axi.RREADY = rsp_ready && !rst;
        rsp_valid  = axi.RVALID && !rst;
        rsp_last   = axi.RLAST;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_master_read_channel.sv
// Directed bench for axi_master_read_channel with a transaction-level model.
module tb_axi_master_read_channel;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          done;
  logic          err;

  axi_master_read_channel_if #(.ADDR_WIDTH(AW), .READ_CHANNEL_WIDTH(DW), .READ_BURST_LEN(LW)) bus ();

  axi_master_read_channel #(
    .ADDR_WIDTH(AW), .READ_CHANNEL_WIDTH(DW), .READ_BURST_LEN(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .done(done), .err(err), .axi(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase of the current transaction (0 idle, 1 address, 2 data, 3 done).
  int            m_phase = 0;
  logic [AW-1:0] m_addr  = '0;
  logic [LW-1:0] m_len   = '0;
  int            m_cnt   = 0;
  bit            m_err   = 1'b0;
  // Observations accumulated per burst, pinned against literals by the stimulus.
  int            done_cnt = 0;
  bit            last_err = 1'b0;
  int            beats_seen = 0;
  logic [DW-1:0] first_data = '0;
  logic [DW-1:0] last_data  = '0;
  int            arvalid_cycles = 0;

  // Compare DUT outputs against the model once per cycle, away from the active edge.
  initial forever begin
    int nxt;
    @(negedge clk);
    nxt = m_phase;
    check("arsize", 64'(bus.ARSIZE), 64'd2);
    check("arburst", 64'(bus.ARBURST), 64'd1);
    if (rst) begin
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      nxt = 0;
    end else begin
      check("req_ready", 64'(req_ready), 64'(m_phase == 0));
      check("arvalid", 64'(bus.ARVALID), 64'(m_phase == 1));
      check("done", 64'(done), 64'(m_phase == 3));
      check("err", 64'(err), 64'((m_phase == 3) ? m_err : 1'b0));
      if (done) begin
        done_cnt++;
        last_err = err;
      end
      if (bus.ARVALID) arvalid_cycles++;
      case (m_phase)
        0: begin
          check("idle_rready", 64'(bus.RREADY), 64'd0);
          check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
          if (req_valid) begin
            m_addr = req_addr;
            m_len  = req_len;
            m_cnt  = 0;
            m_err  = 1'b0;
            nxt    = 1;
          end
        end
        1: begin
          check("araddr", 64'(bus.ARADDR), 64'(m_addr));
          check("arlen", 64'(bus.ARLEN), 64'(m_len));
          check("addr_rready", 64'(bus.RREADY), 64'd0);
          check("addr_rsp_valid", 64'(rsp_valid), 64'd0);
          if (bus.ARREADY) nxt = 2;
        end
        2: begin
          check("rready", 64'(bus.RREADY), 64'(rsp_ready));
          check("rsp_valid", 64'(rsp_valid), 64'(bus.RVALID));
          if (bus.RVALID) begin
            check("rsp_data", 64'(rsp_data), 64'(bus.RDATA));
            check("rsp_last", 64'(rsp_last), 64'(bus.RLAST));
          end
          if (bus.RVALID && rsp_ready) begin
            if (bus.RRESP[1]) m_err = 1'b1;
            if (bus.RLAST != (m_cnt == int'(m_len))) m_err = 1'b1;
            if (beats_seen == 0) first_data = rsp_data;
            last_data = rsp_data;
            beats_seen++;
            m_cnt++;
            if (bus.RLAST) nxt = 3;
          end
        end
        default: begin
          check("done_rready", 64'(bus.RREADY), 64'd0);
          check("done_rsp_valid", 64'(rsp_valid), 64'd0);
          nxt = 0;
        end
      endcase
    end
    m_phase = nxt;
  end

  // One request plus slave response; bad_idx gets SLVERR, last_idx carries RLAST,
  // rst_idx asserts reset while that beat is presented (-1 disables each).
  task automatic burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                       input int ar_dly, input int nbeats, input logic [DW-1:0] base,
                       input int bad_idx, input int last_idx, input bit toggle,
                       input int rst_idx);
    int  i;
    int  guard;
    bit  tog;
    bit  ok;
    done_cnt = 0; last_err = 1'b0; beats_seen = 0; arvalid_cycles = 0;
    ok = 1'b0;
    for (int g = 0; g < 20; g++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("req_ready_timeout", 64'd0, 64'd1);
    req_valid = 1'b1; req_addr = addr; req_len = len;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_len = 8'hFF;
    // A stray beat during the address phase must be ignored.
    bus.RVALID = 1'b1; bus.RDATA = 32'hDEAD_BEEF; bus.RLAST = 1'b1; bus.RRESP = 2'b10;
    repeat (ar_dly) begin @(posedge clk); #1; end
    bus.ARREADY = 1'b1;
    @(posedge clk); #1;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
    i = 0; guard = 0; tog = 1'b1;
    while (i < nbeats && guard < 1000) begin
      bus.RVALID = 1'b1;
      bus.RDATA  = base + DW'(i);
      bus.RRESP  = (i == bad_idx) ? 2'b10 : 2'b00;
      bus.RLAST  = (i == last_idx);
      rsp_ready  = toggle ? tog : 1'b1;
      if (i == rst_idx) rst = 1'b1;
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        break;
      end
      if (rsp_ready) i++;
      tog = ~tog;
      guard++;
    end
    if (guard >= 1000) check("beat_timeout", 64'd0, 64'd1);
    bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00; rsp_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b1;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
    repeat (3) begin @(posedge clk); #1; end
    check("reset_arvalid", 64'(bus.ARVALID), 64'd0);
    check("reset_araddr", 64'(bus.ARADDR), 64'd0);
    check("reset_arlen", 64'(bus.ARLEN), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_reset_req_ready", 64'(req_ready), 64'd1);

    // Basic 4-beat burst, ARREADY immediately.
    burst(32'h1000, 8'd3, 0, 4, 32'hA0, -1, 3, 1'b0, -1);
    check("t1_beats", 64'(beats_seen), 64'd4);
    check("t1_first", 64'(first_data), 64'hA0);
    check("t1_last", 64'(last_data), 64'hA3);
    check("t1_arvalid_cycles", 64'(arvalid_cycles), 64'd1);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_err", 64'(last_err), 64'd0);

    // ARREADY delayed five cycles.
    burst(32'h1000, 8'd3, 5, 4, 32'hB0, -1, 3, 1'b0, -1);
    check("t2_arvalid_cycles", 64'(arvalid_cycles), 64'd6);
    check("t2_beats", 64'(beats_seen), 64'd4);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);

    // Client backpressure toggling every cycle.
    burst(32'h2000, 8'd3, 1, 4, 32'hC0, -1, 3, 1'b1, -1);
    check("t3_beats", 64'(beats_seen), 64'd4);
    check("t3_last", 64'(last_data), 64'hC3);
    check("t3_done_cnt", 64'(done_cnt), 64'd1);

    // SLVERR on beat 2, then a clean burst clears the accumulator.
    burst(32'h3000, 8'd3, 0, 4, 32'hD0, 2, 3, 1'b0, -1);
    check("t4_beats", 64'(beats_seen), 64'd4);
    check("t4_err", 64'(last_err), 64'd1);
    burst(32'h3100, 8'd3, 0, 4, 32'hE0, -1, 3, 1'b0, -1);
    check("t4b_err", 64'(last_err), 64'd0);
    check("t4b_done_cnt", 64'(done_cnt), 64'd1);

    // Early RLAST on beat 2 of a 4-beat request.
    burst(32'h4000, 8'd3, 0, 3, 32'hF0, -1, 2, 1'b0, -1);
    check("t5_beats", 64'(beats_seen), 64'd3);
    check("t5_err", 64'(last_err), 64'd1);
    check("t5_done_cnt", 64'(done_cnt), 64'd1);

    // Maximum length burst: 256 beats.
    burst(32'h5000, 8'd255, 0, 256, 32'h100, -1, 255, 1'b0, -1);
    check("t6_beats", 64'(beats_seen), 64'd256);
    check("t6_last", 64'(last_data), 64'h1FF);
    check("t6_err", 64'(last_err), 64'd0);
    check("t6_done_cnt", 64'(done_cnt), 64'd1);

    // Reset in the middle of the data phase, then a normal burst.
    burst(32'h6000, 8'd3, 0, 4, 32'h60, -1, 3, 1'b0, 1);
    check("t7_beats", 64'(beats_seen), 64'd1);
    check("t7_no_done", 64'(done_cnt), 64'd0);
    check("t7_req_ready", 64'(req_ready), 64'd1);
    burst(32'h7000, 8'd1, 0, 2, 32'h70, -1, 1, 1'b0, -1);
    check("t7b_beats", 64'(beats_seen), 64'd2);
    check("t7b_done_cnt", 64'(done_cnt), 64'd1);
    check("t7b_err", 64'(last_err), 64'd0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
